// File: rtl/mem_mailbox.sv
// Mailbox queue slave behind the arbiter grant mux: rd/wr/rdy handshake with wait states.
// Optional MBX_RAND_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per access.
module mem_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WAIT  = 2,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd,
  input  logic                         wr,
  output logic                         rdy,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state;
  logic [4:0]    wcnt;
  logic [4:0]    load;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [7:0]    mem [DEPTH];
  logic          full;
  logic          empty;

`ifdef MBX_RAND_WAIT_EN
  logic [7:0] lfsr;

  // Fibonacci x^8+x^6+x^5+x^4+1, free-running every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load = 5'(WAIT) + {3'b000, lfsr[1:0]};
`else
  assign load = 5'(WAIT);
`endif

  assign rdy   = (state == S_ACK);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd | wr) begin
            if (load == '0) begin
              state <= S_ACK;
            end else begin
              state <= S_WAIT;
              wcnt  <= load;
            end
          end
        end
        S_WAIT: begin
          if (!(rd | wr))        state <= S_IDLE;
          else if (wcnt == 5'd1) state <= S_ACK;
          else                   wcnt  <= wcnt - 5'd1;
        end
        S_ACK: begin
          state <= S_IDLE;
          // Operation is decided by the live inputs; a simultaneous rd+wr is a write
          if (wr) begin
            if (!full) begin
              wp    <= wp + 1'b1;
              count <= count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else if (rd) begin
            if (!empty) begin
              rdata <= mem[rp];
              rp    <= rp + 1'b1;
              count <= count - 1'b1;
            end else begin
              rdata     <= 8'h00;
              underflow <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_ACK && wr && !full) mem[wp] <= wdata;
  end

endmodule

// File: tb/tb_mem_mailbox.sv
// Self-checking bench for mem_mailbox: directed cases plus randomized accesses
// checked against a queue-based reference model.
module tb_mem_mailbox;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WAIT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd  = 1'b0;
  logic       wr  = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rdy;
  logic [7:0] rdata;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  byte unsigned q[$];
  int unsigned  m_rdata = 0;
  int unsigned  m_ovf   = 0;
  int unsigned  m_udf   = 0;

  mem_mailbox #(.DEPTH(DEPTH), .WAIT(WAIT), .SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .rdy       (rdy),
    .wdata     (wdata),
    .rdata     (rdata),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_count"}, count, q.size());
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_udf"}, underflow, m_udf);
  endtask

  // Called just after an active edge with the FSM idle; returns just after the completing edge.
  task automatic access(input logic r, input logic w, input logic [7:0] d);
    int unsigned lat  = 0;
    bit          seen = 1'b0;
    rd = r; wr = w; wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("rdy_seen", seen, 1);
    if (!seen) begin
      rd = 1'b0; wr = 1'b0;
      return;
    end
`ifdef MBX_RAND_WAIT_EN
    check("lat_range", (lat >= 3 && lat <= 6) ? 1 : 0, 1);
`else
    check("latency", lat, 1 + WAIT);
`endif
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    if (w) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1;
    end else if (r) begin
      if (q.size() > 0) m_rdata = q.pop_front();
      else begin
        m_rdata = 0;
        m_udf   = 1;
      end
    end
    check("rdy_pulse", rdy, 0);
    check_state("acc");
  endtask

  initial begin
    int unsigned op;
    int unsigned saved;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 0);
    check_state("rst");
    rst = 1'b0;

    // write A5, 3C then read both back in order
    access(1'b0, 1'b1, 8'hA5);
    access(1'b0, 1'b1, 8'h3C);
    access(1'b1, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h00);

    // fill past full, then drain
    for (int i = 1; i <= 9; i++) access(1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 8; i++) access(1'b1, 1'b0, 8'h00);

    // read while empty
    access(1'b1, 1'b0, 8'h00);

    // aborted write: request dropped while waiting
    saved = q.size();
    wr = 1'b1; wdata = 8'h55;
    @(posedge clk); #1;
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_rdy", rdy, 0);
    end
    check("abort_count", count, saved);

    // rd and wr together act as a write only
    access(1'b1, 1'b1, 8'h77);
    access(1'b1, 1'b0, 8'h00);

    for (int n = 0; n < 64; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0:       access(1'b1, 1'b0, 8'($urandom));
        3:       access(1'b1, 1'b1, 8'($urandom));
        default: access(1'b0, 1'b1, 8'($urandom));
      endcase
    end

    // asynchronous reset in the middle of an access
    access(1'b0, 1'b1, 8'h11);
    wr = 1'b1; wdata = 8'h22;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_rdata = 0; m_ovf = 0; m_udf = 0;
    check("arst_rdy", rdy, 0);
    check_state("arst");
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
